// File: rtl/lcd_pkg.sv
// Shared types, HD44780 command constants and helpers for the LCD write arbiter.
package lcd_pkg;

  typedef enum logic [2:0] {
    StInitWait,
    StInitIssue,
    StIdle,
    StSetup,
    StPulse,
    StHold,
    StExec
  } lcd_state_e;

  localparam logic [7:0] CMD_FUNCTION_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON      = 8'h0C;
  localparam logic [7:0] CMD_ENTRY_MODE   = 8'h06;
  localparam logic [7:0] CMD_CLEAR        = 8'h01;
  localparam logic [7:0] CMD_HOME         = 8'h02;

  // Clear and both home encodings (0x02/0x03) need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == CMD_CLEAR || data == CMD_HOME || data == 8'h03);
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    logic [7:0] cmd;
    case (idx)
      2'd0:    cmd = CMD_FUNCTION_SET;
      2'd1:    cmd = CMD_DISP_ON;
      2'd2:    cmd = CMD_ENTRY_MODE;
      default: cmd = CMD_CLEAR;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/lcd_rr_arbiter.sv
// Two-way round-robin grant logic plus the last_grant register.
module lcd_rr_arbiter (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req0_i,
  input  logic req1_i,
  input  logic take_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  logic last_grant_q;

  // On a tie the port that did not win last time goes first.
  always_comb begin
    gnt0_o = req0_i & (~req1_i | last_grant_q);
    gnt1_o = req1_i & ~gnt0_o;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_grant_q <= 1'b1;
    end else if (take_i && (gnt0_o || gnt1_o)) begin
      last_grant_q <= gnt1_o;
    end
  end

endmodule

// File: rtl/lcd_write_arbiter.sv
// Shares one HD44780 write port between two requesters; each grant is one timed write cycle.
// Define LCD_INIT_SEQ_EN to run the power-up wait and init command sequence after reset.
module lcd_write_arbiter
  import lcd_pkg::*;
#(
  parameter int unsigned T_SETUP   = 2,
  parameter int unsigned T_PULSE   = 12,
  parameter int unsigned T_HOLD    = 2,
  parameter int unsigned T_EXEC    = 40,
  parameter int unsigned T_CLEAR   = 1600,
`ifdef LCD_INIT_SEQ_EN
  parameter int unsigned T_POWERUP = 20000,
`endif
  parameter int unsigned CNT_W     = 16
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       REQ0,
  input  logic       RS0,
  input  logic [7:0] DATA0,
  output logic       ACK0,
  input  logic       REQ1,
  input  logic       RS1,
  input  logic [7:0] DATA1,
  output logic       ACK1,
  output logic       BUSY,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_E
);

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(T_EXEC - 1);
  localparam logic [CNT_W-1:0] CLEAR_LD = CNT_W'(T_CLEAR - 1);

`ifdef LCD_INIT_SEQ_EN
  localparam lcd_state_e       RST_STATE = StInitWait;
  localparam logic [CNT_W-1:0] RST_CNT   = CNT_W'(T_POWERUP - 1);
  logic [2:0] init_idx_q;
`else
  localparam lcd_state_e       RST_STATE = StIdle;
  localparam logic [CNT_W-1:0] RST_CNT   = '0;
`endif

  lcd_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             gnt0, gnt1;
  logic             cnt_done;

  lcd_rr_arbiter u_arb (
    .clk_i  (CLK),
    .rst_ni (RESETN),
    .req0_i (REQ0),
    .req1_i (REQ1),
    .take_i (state_q == StIdle),
    .gnt0_o (gnt0),
    .gnt1_o (gnt1)
  );

  assign cnt_done = (cnt_q == '0);
  assign BUSY     = (state_q != StIdle);
  assign LCD_RW   = 1'b0;

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q  <= RST_STATE;
      cnt_q    <= RST_CNT;
      ACK0     <= 1'b0;
      ACK1     <= 1'b0;
      LCD_E    <= 1'b0;
      LCD_RS   <= 1'b0;
      LCD_DATA <= 8'h00;
`ifdef LCD_INIT_SEQ_EN
      init_idx_q <= 3'd0;
`endif
    end else begin
      ACK0 <= 1'b0;
      ACK1 <= 1'b0;
      case (state_q)
        StIdle: begin
          if (gnt0) begin
            ACK0     <= 1'b1;
            LCD_RS   <= RS0;
            LCD_DATA <= DATA0;
            state_q  <= StSetup;
            cnt_q    <= SETUP_LD;
          end else if (gnt1) begin
            ACK1     <= 1'b1;
            LCD_RS   <= RS1;
            LCD_DATA <= DATA1;
            state_q  <= StSetup;
            cnt_q    <= SETUP_LD;
          end
        end
        StSetup: begin
          if (cnt_done) begin
            state_q <= StPulse;
            LCD_E   <= 1'b1;
            cnt_q   <= PULSE_LD;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        StPulse: begin
          if (cnt_done) begin
            state_q <= StHold;
            LCD_E   <= 1'b0;
            cnt_q   <= HOLD_LD;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        StHold: begin
          if (cnt_done) begin
            state_q <= StExec;
            cnt_q   <= is_long_cmd(LCD_RS, LCD_DATA) ? CLEAR_LD : EXEC_LD;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        StExec: begin
          if (cnt_done) begin
`ifdef LCD_INIT_SEQ_EN
            state_q <= (init_idx_q != 3'd4) ? StInitIssue : StIdle;
`else
            state_q <= StIdle;
`endif
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
`ifdef LCD_INIT_SEQ_EN
        StInitWait: begin
          if (cnt_done) begin
            state_q <= StInitIssue;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        StInitIssue: begin
          LCD_RS     <= 1'b0;
          LCD_DATA   <= init_cmd(init_idx_q[1:0]);
          init_idx_q <= init_idx_q + 3'd1;
          state_q    <= StSetup;
          cnt_q      <= SETUP_LD;
        end
`endif
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Self-checking bench for lcd_write_arbiter (default build, init sequence disabled).
module tb_lcd_write_arbiter;

  localparam int S = 2;
  localparam int P = 12;
  localparam int H = 2;
  localparam int X = 40;
  localparam int C = 1600;

  logic       CLK = 1'b0;
  logic       RESETN = 1'b0;
  logic       REQ0 = 1'b0, RS0 = 1'b0, REQ1 = 1'b0, RS1 = 1'b0;
  logic [7:0] DATA0 = 8'h00, DATA1 = 8'h00;
  logic       ACK0, ACK1, BUSY, LCD_RS, LCD_RW, LCD_E;
  logic [7:0] LCD_DATA;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int ack0_n = 0;
  int ack1_n = 0;

  lcd_write_arbiter dut (
    .CLK      (CLK),
    .RESETN   (RESETN),
    .REQ0     (REQ0),
    .RS0      (RS0),
    .DATA0    (DATA0),
    .ACK0     (ACK0),
    .REQ1     (REQ1),
    .RS1      (RS1),
    .DATA1    (DATA1),
    .ACK1     (ACK1),
    .BUSY     (BUSY),
    .LCD_DATA (LCD_DATA),
    .LCD_RS   (LCD_RS),
    .LCD_RW   (LCD_RW),
    .LCD_E    (LCD_E)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Transaction-level model: a grant starts a write of known length; outputs are
  // a function of the offset k from the ACK cycle.
  bit         m_busy = 0;
  int         m_k = 0;
  int         m_total = 0;
  int         m_last = 1;
  int         m_port = 0;
  logic       m_rs = 1'b0;
  logic [7:0] m_data = 8'h00;

  always @(posedge CLK) begin
    cyc++;
    if (!RESETN) begin
      m_busy = 0;
      m_last = 1;
      m_rs   = 1'b0;
      m_data = 8'h00;
      m_k    = 0;
    end else if (m_busy) begin
      m_k++;
      if (m_k == m_total) m_busy = 0;
    end else if (REQ0 || REQ1) begin
      if (REQ0 && REQ1) m_port = 1 - m_last;
      else m_port = REQ0 ? 0 : 1;
      m_last  = m_port;
      m_rs    = (m_port == 0) ? RS0 : RS1;
      m_data  = (m_port == 0) ? DATA0 : DATA1;
      m_total = S + P + H + ((!m_rs && m_data inside {8'h01, 8'h02, 8'h03}) ? C : X);
      m_busy  = 1;
      m_k     = 0;
    end
  end

  always @(negedge CLK) begin
    if (cyc > 0) begin
      check("ack0", ACK0, m_busy && m_k == 0 && m_port == 0);
      check("ack1", ACK1, m_busy && m_k == 0 && m_port == 1);
      check("busy", BUSY, m_busy);
      check("lcd_e", LCD_E, m_busy && m_k >= S && m_k < S + P);
      check("lcd_rs", LCD_RS, m_rs);
      check("lcd_data", LCD_DATA, m_data);
      check("lcd_rw", LCD_RW, 1'b0);
      if (ACK0 === 1'b1) ack0_n++;
      if (ACK1 === 1'b1) ack1_n++;
    end
  end

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic wait_ack(input int port, input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      step();
      if (((port == 0) ? ACK0 : ACK1) === 1'b1) begin
        at = cyc;
        break;
      end
    end
    n_cmp++;
    if (at < 0) begin
      n_err++;
      $display("FAIL ack%0d_timeout: got no ACK, expected one within %0d cycles", port, bound);
    end
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (BUSY !== 1'b0 && n < bound) begin
      step();
      n++;
    end
    check("idle_timeout", BUSY, 1'b0);
  endtask

  int a1, a2, e_cnt, e_first, bad, busy_n, base, rel;
  int seq[4];

  initial begin
    repeat (3) step();
    check("rst_e", LCD_E, 1'b0);
    check("rst_data", LCD_DATA, 8'h00);
    check("rst_ack0", ACK0, 1'b0);
    check("rst_busy", BUSY, 1'b0);
    RESETN = 1'b1;
    step();

    // Single data write, request held to measure back-to-back latency.
    REQ0 = 1'b1; RS0 = 1'b1; DATA0 = 8'h41;
    wait_ack(0, 10, a1);
    e_cnt = 0; e_first = -1; bad = 0;
    for (int i = 1; i <= 56; i++) begin
      step();
      if (LCD_E === 1'b1) begin
        e_cnt++;
        if (e_first < 0) e_first = i;
        if (LCD_DATA !== 8'h41 || LCD_RS !== 1'b1) bad++;
      end
    end
    check("t1_e_len", e_cnt, 12);
    check("t1_e_start", e_first, 2);
    check("t1_data", bad, 0);
    wait_ack(0, 5, a2);
    check("t1_latency", a2 - a1, 57);
    REQ0 = 1'b0;
    wait_idle(200);

    // Round robin from reset with both requests held.
    RESETN = 1'b0;
    step(); step();
    REQ0 = 1'b1; RS0 = 1'b1; DATA0 = 8'h30;
    REQ1 = 1'b1; RS1 = 1'b1; DATA1 = 8'h31;
    RESETN = 1'b1;
    base = ack0_n;
    for (int g = 0; g < 4; g++) begin
      seq[g] = -1;
      for (int i = 0; i < 100; i++) begin
        step();
        if (ACK0 === 1'b1) begin seq[g] = 0; break; end
        if (ACK1 === 1'b1) begin seq[g] = 1; break; end
      end
    end
    REQ0 = 1'b0; REQ1 = 1'b0;
    check("t2_g0", seq[0], 0);
    check("t2_g1", seq[1], 1);
    check("t2_g2", seq[2], 0);
    check("t2_g3", seq[3], 1);
    check("t2_port0_acks", ack0_n - base, 2);
    wait_idle(200);

    // Clear command takes the long execution wait.
    step();
    REQ1 = 1'b1; RS1 = 1'b0; DATA1 = 8'h01;
    wait_ack(1, 10, a1);
    REQ1 = 1'b0;
    busy_n = 1;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (BUSY !== 1'b1) break;
      busy_n++;
    end
    check("t3_busy_len", busy_n, 1616);

    // Reset in the middle of the E pulse, request held across it.
    step();
    REQ0 = 1'b1; RS0 = 1'b1; DATA0 = 8'h55;
    wait_ack(0, 10, a1);
    repeat (5) step();
    check("t4_in_pulse", LCD_E, 1'b1);
    RESETN = 1'b0;
    base = ack0_n + ack1_n;
    step();
    check("t4_e_low", LCD_E, 1'b0);
    check("t4_data_clr", LCD_DATA, 8'h00);
    step(); step();
    check("t4_no_ack_in_rst", ack0_n + ack1_n - base, 0);
    RESETN = 1'b1;
    rel = cyc;
    wait_ack(0, 3, a2);
    check("t4_regrant", a2 - rel, 1);
    REQ0 = 1'b0;
    wait_idle(200);

    // Short request pulse during EXEC is ignored.
    step();
    REQ1 = 1'b1; RS1 = 1'b1; DATA1 = 8'h42;
    wait_ack(1, 10, a1);
    REQ1 = 1'b0;
    repeat (25) step();
    base = ack0_n;
    REQ0 = 1'b1; RS0 = 1'b1; DATA0 = 8'h77;
    repeat (5) step();
    check("t5_still_busy", BUSY, 1'b1);
    REQ0 = 1'b0;
    repeat (80) step();
    check("t5_no_ack0", ack0_n - base, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
